bus_device_port: RTL
====================

BUS_DEVICE_PORT -- requirements
Module: bus_device_port

Interface
REQ-001 Parameter pckg_sz, default 16, packet width in bits.
REQ-002 Parameter depth, default 8, entries per FIFO; power of two, >= 2.
REQ-003 Parameter cw, default $clog2(depth)+1, count width; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  device-side write into the TX FIFO.
REQ-007 wr_data  input  pckg_sz  packet written into the TX FIFO.
REQ-008 tx_full  output  1  TX FIFO holds depth entries.
REQ-009 tx_count  output  cw  TX FIFO occupancy.
REQ-010 pndng  output  1  bus side; TX FIFO non-empty, packet pending.
REQ-011 D_pop  output  pckg_sz  bus side; head-of-TX packet.
REQ-012 pop  input  1  bus side; bus consumes the head TX packet.
REQ-013 push  input  1  bus side; bus delivers a packet to this device.
REQ-014 D_push  input  pckg_sz  bus side; delivered packet.
REQ-015 rd_en  input  1  device-side read from the RX FIFO.
REQ-016 rd_data  output  pckg_sz  head-of-RX packet.
REQ-017 rx_empty  output  1  RX FIFO holds no entries.
REQ-018 rx_count  output  cw  RX FIFO occupancy.
REQ-019 err_flags  output  3  sticky errors: [0] tx_overflow, [1] pop_on_empty, [2] rx_overflow.

Function
REQ-020 Both FIFOs SHALL be first-word-fall-through: D_pop and rd_data SHALL show the head entry combinationally from stored state, with no read latency.
REQ-021 pndng SHALL equal (tx_count != 0); D_pop SHALL be all zeros while pndng is 0.
REQ-022 rx_empty SHALL equal (rx_count == 0); rd_data SHALL be all zeros while rx_empty is 1.
REQ-023 tx_full SHALL equal (tx_count == depth).
REQ-024 wr_en while not full SHALL store wr_data at the tail; the entry is visible on D_pop and pndng on the next cycle.
REQ-025 pop while pndng is 1 SHALL advance the TX head; the next entry, or zeros, appears the next cycle.
REQ-026 wr_en and pop together with tx_full SHALL accept both, leaving tx_count unchanged.
REQ-027 wr_en with tx_full and no pop SHALL drop the packet and set err_flags[0].
REQ-028 pop with pndng 0 SHALL be ignored and set err_flags[1], including when wr_en is high in the same cycle; that write is still accepted.
REQ-029 push while RX is not full, or is full with rd_en in the same cycle, SHALL store D_push at the RX tail.
REQ-030 push with RX full and no rd_en SHALL drop the packet and set err_flags[2].
REQ-031 rd_en while RX is non-empty SHALL advance the RX head; rd_en while empty SHALL be ignored, with no flag.
REQ-032 Pointers SHALL be log2(depth) bits and wrap modulo depth; counts SHALL never exceed depth or go below 0.
REQ-033 Packets SHALL leave each FIFO in arrival order, bit-exact, with no reordering or duplication.
REQ-034 err_flags bits SHALL stay set until reset.

Reset
REQ-035 With reset high at a clock edge, all pointers, tx_count, rx_count and err_flags SHALL become 0; storage contents need not be cleared.
REQ-036 After reset: pndng=0, D_pop=0, tx_full=0, rx_empty=1, rd_data=0.
REQ-037 wr_en, pop, push and rd_en SHALL be ignored in any cycle where reset is high.
REQ-038 Reset mid-operation SHALL discard all buffered packets.

Verification
REQ-039 Reset, then write 0x1111, 0x2222 -> pndng=1 next cycle, D_pop=0x1111; pop -> D_pop=0x2222; pop -> pndng=0, D_pop=0.
REQ-040 Write 8 packets (depth=8) -> tx_full=1, tx_count=8; a 9th write -> dropped, err_flags[0]=1; wr_en+pop at full -> tx_count stays 8, FIFO order preserved.
REQ-041 pop while empty -> err_flags=3'b010, tx_count=0; a simultaneous write 0xABCD -> D_pop=0xABCD next cycle.
REQ-042 Push 0xA000..0xA007, then push 0xBEEF -> err_flags[2]=1, rx_count=8; read 8 times -> rd_data 0xA000..0xA007 in order, then rx_empty=1.
REQ-043 Stream 20 writes/pops and 20 pushes/reads interleaved -> pointers wrap correctly, scoreboard matches every packet.
REQ-044 Fill TX to 5 and RX to 3, set err_flags[0], assert reset 1 cycle -> all counts 0, err_flags=0, pndng=0, rx_empty=1.

Source files
------------

// File: rtl/bus_device_port.sv
// Bus-side device port: a TX FIFO (device writes, bus pops) and an RX FIFO
// (bus pushes, device reads), both first-word-fall-through, with sticky error flags.
module bus_device_port #(
    parameter int pckg_sz = 16,
    parameter int depth   = 8,
    parameter int cw      = $clog2(depth) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    output logic [cw-1:0]      tx_count,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rx_empty,
    output logic [cw-1:0]      rx_count,
    output logic [2:0]         err_flags
);

    localparam int aw = $clog2(depth);
    localparam logic [cw-1:0] fullCount = cw'(depth);

    logic [pckg_sz-1:0] txMem_q [depth];
    logic [pckg_sz-1:0] rxMem_q [depth];

    logic [aw-1:0] txWrPtr_q, txWrPtr_d, txRdPtr_q, txRdPtr_d;
    logic [aw-1:0] rxWrPtr_q, rxWrPtr_d, rxRdPtr_q, rxRdPtr_d;
    logic [cw-1:0] txCount_q, txCount_d, rxCount_q, rxCount_d;
    logic [2:0]    errFlags_q, errFlags_d;

    logic txFull, txEmpty, txPush, txPop;
    logic rxFull, rxEmpty, rxPush, rxPop;

    // A pop at full frees a slot in the same cycle, so a simultaneous write is accepted.
    always_comb begin
        txFull  = (txCount_q == fullCount);
        txEmpty = (txCount_q == '0);
        txPop   = pop && !txEmpty;
        txPush  = wr_en && (!txFull || txPop);

        rxFull  = (rxCount_q == fullCount);
        rxEmpty = (rxCount_q == '0);
        rxPop   = rd_en && !rxEmpty;
        rxPush  = push && (!rxFull || rxPop);
    end

    always_comb begin
        txWrPtr_d  = txWrPtr_q + aw'(txPush);
        txRdPtr_d  = txRdPtr_q + aw'(txPop);
        txCount_d  = txCount_q + cw'(txPush) - cw'(txPop);
        rxWrPtr_d  = rxWrPtr_q + aw'(rxPush);
        rxRdPtr_d  = rxRdPtr_q + aw'(rxPop);
        rxCount_d  = rxCount_q + cw'(rxPush) - cw'(rxPop);
        errFlags_d = errFlags_q | {push && rxFull && !rd_en,
                                   pop && txEmpty,
                                   wr_en && txFull && !pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txWrPtr_q  <= '0;
            txRdPtr_q  <= '0;
            txCount_q  <= '0;
            rxWrPtr_q  <= '0;
            rxRdPtr_q  <= '0;
            rxCount_q  <= '0;
            errFlags_q <= '0;
        end else begin
            txWrPtr_q  <= txWrPtr_d;
            txRdPtr_q  <= txRdPtr_d;
            txCount_q  <= txCount_d;
            rxWrPtr_q  <= rxWrPtr_d;
            rxRdPtr_q  <= rxRdPtr_d;
            rxCount_q  <= rxCount_d;
            errFlags_q <= errFlags_d;
        end
    end

    // Storage is never cleared; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && txPush) txMem_q[txWrPtr_q] <= wr_data;
        if (!reset && rxPush) rxMem_q[rxWrPtr_q] <= D_push;
    end

    assign tx_full   = txFull;
    assign tx_count  = txCount_q;
    assign pndng     = !txEmpty;
    assign D_pop     = txEmpty ? '0 : txMem_q[txRdPtr_q];
    assign rx_empty  = rxEmpty;
    assign rx_count  = rxCount_q;
    assign rd_data   = rxEmpty ? '0 : rxMem_q[rxRdPtr_q];
    assign err_flags = errFlags_q;

endmodule
